led7_scan_mux: RTL and testbench

- Upstream stage of the 7-segment decoder for a 4-digit multiplexed common-anode display.
- Holds a 16-bit display value of four hex/BCD nibbles and scans the digits in turn.
- Drives the current nibble to the decoder's 4-bit input and drives the active-low anode enables and decimal point.
- Inserts a blanking gap between digits to prevent ghosting, and commits new values only at frame boundaries so the display never tears.

---
 rtl/led7_scan_mux_pkg.sv | 7 +
 rtl/led7_scan_mux_if.sv | 14 +
 rtl/led7_scan_mux_timer.sv | 33 +++
 rtl/led7_scan_mux.sv | 61 ++++++
 tb/tb_led7_scan_mux.sv | 106 ++++++++++
 5 files changed

// File: rtl/led7_scan_mux_pkg.sv
// led7_pkg: shared constants and scan state type for the 4-digit LED scan multiplexer.
package led7_pkg;
  localparam int N_DIGITS = 4;
  localparam int NIB_W = 4;
  localparam int CNT_W = 20;
  typedef enum logic {BLANK, SHOW} scan_state_t;
endpackage

// File: rtl/led7_scan_mux_if.sv
// led7_scan_mux_if: display value load bus and scan outputs of the LED multiplexer.
interface led7_scan_mux_if;
  import led7_pkg::*;
  logic [N_DIGITS*NIB_W-1:0] data_in;
  logic load;
  logic [N_DIGITS-1:0] dp_in;
  logic [N_DIGITS-1:0] digit_en;
  logic [NIB_W-1:0] nib_out;
  logic [N_DIGITS-1:0] an_n;
  logic dp_n;
  logic frame_tick;
  modport master(output data_in, load, dp_in, digit_en, input nib_out, an_n, dp_n, frame_tick);
  modport slave(input data_in, load, dp_in, digit_en, output nib_out, an_n, dp_n, frame_tick);
endinterface

// File: rtl/led7_scan_mux_timer.sv
// led7_scan_timer: slot prescaler; blank/show phase, digit index, digit-advance and frame-wrap strobes.
module led7_scan_timer import led7_pkg::*; #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output scan_state_t phase,
  output logic [1:0]  idx,
  output logic        digit_adv,
  output logic        frame_wrap
);
  scan_state_t st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0] idx_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= BLANK;
      cnt <= '0;
      idx <= '0;
    end else begin
      phase <= st_nxt;
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  always_comb begin
    digit_adv = phase == SHOW && cnt == CNT_W'(SCAN_DIV - 1);
    frame_wrap = digit_adv && idx == 2'(N_DIGITS - 1);
    st_nxt = digit_adv ? BLANK : (phase == BLANK && cnt == CNT_W'(BLANK_CYC - 1)) ? SHOW : phase;
    cnt_nxt = digit_adv ? '0 : cnt + 1'b1;
    idx_nxt = idx + {1'b0, digit_adv};
  end
endmodule

// File: rtl/led7_scan_mux.sv
// led7_scan_mux: 4-digit common-anode scan with blanking gaps and frame-boundary commit.
// Optional leading-zero blanking when LED7_LZB_EN is defined.
module led7_scan_mux import led7_pkg::*; #(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYC = 16
) (
  input logic clk,
  input logic rst_n,
  led7_scan_mux_if.slave bus
);
  localparam int W = N_DIGITS * NIB_W;
  scan_state_t phase;
  logic [1:0] idx, idx_n;
  logic digit_adv, frame_wrap, pending_valid, lit;
  logic [W-1:0] active, pending, act_nxt;
  logic [N_DIGITS-1:0] active_dp, pending_dp, dp_nxt, en_q, sup;
`ifdef LED7_LZB_EN
  logic z;
`endif
  led7_scan_timer #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) u_timer (
    .clk(clk), .rst_n(rst_n), .phase(phase), .idx(idx), .digit_adv(digit_adv), .frame_wrap(frame_wrap)
  );
  always_comb begin
    act_nxt = frame_wrap && bus.load ? bus.data_in : frame_wrap && pending_valid ? pending : active;
    dp_nxt = frame_wrap && bus.load ? bus.dp_in : frame_wrap && pending_valid ? pending_dp : active_dp;
    idx_n = idx + 2'd1;
    sup = '0;
`ifdef LED7_LZB_EN
    z = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      z = z && active[k*NIB_W +: NIB_W] == '0;
      sup[k] = z;
    end
`endif
    lit = phase == SHOW && en_q[idx] && !sup[idx];
    bus.an_n = lit ? ~(N_DIGITS'(1) << idx) : '1;
    bus.dp_n = !(lit && active_dp[idx]);
    bus.frame_tick = frame_wrap;
  end
  // nib_out changes only when a slot's blank phase begins, ahead of the anode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      active <= '0;
      active_dp <= '0;
      pending <= '0;
      pending_dp <= '0;
      pending_valid <= 1'b0;
      en_q <= '0;
      bus.nib_out <= '0;
    end else begin
      active <= act_nxt;
      active_dp <= dp_nxt;
      en_q <= bus.digit_en;
      if (bus.load && !frame_wrap) begin
        pending <= bus.data_in;
        pending_dp <= bus.dp_in;
      end
      pending_valid <= frame_wrap ? 1'b0 : pending_valid || bus.load;
      if (digit_adv) bus.nib_out <= act_nxt[idx_n*NIB_W +: NIB_W];
    end
endmodule

// File: tb/tb_led7_scan_mux.sv
// tb_led7_scan_mux: randomized bench against a time-slot reference model (SCAN_DIV=8, BLANK_CYC=2).
module tb_led7_scan_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0, n_err = 0, t = 0;
  logic [15:0] act_m, pend_m;
  logic [3:0] dp_m, pdp_m, en_prev, en_r;
  logic pv_m;
  led7_scan_mux_if bus();
  led7_scan_mux #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask
  function automatic logic [3:0] sup_m(input logic [15:0] a);
`ifdef LED7_LZB_EN
    int h = 0;
    sup_m = 4'h0;
    for (int k = 0; k < 4; k++) if (a[4*k +: 4] != 4'h0) h = k;
    for (int k = 1; k < 4; k++) if (k > h) sup_m[k] = 1'b1;
`else
    sup_m = 4'h0;
`endif
  endfunction
  task automatic model_reset();
    act_m = '0; pend_m = '0; dp_m = '0; pdp_m = '0; pv_m = 1'b0; en_prev = '0; t = 0;
  endtask
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] en);
    int pos, ix;
    logic on, wrap;
    logic [3:0] s, an_e;
    pos = t % 8;
    ix = (t / 8) % 4;
    s = sup_m(act_m);
    on = pos >= 2 && en_prev[ix] && !s[ix];
    an_e = on ? ~(4'b0001 << ix) : 4'hF;
    wrap = (t % 32) == 31;
    check("an_n", bus.an_n, an_e);
    check("nib_out", bus.nib_out, act_m[4*ix +: 4]);
    check("dp_n", bus.dp_n, on ? !dp_m[ix] : 1'b1);
    check("frame_tick", bus.frame_tick, wrap);
    bus.load = ld; bus.data_in = d; bus.dp_in = p; bus.digit_en = en;
    if (wrap) begin
      if (ld) begin act_m = d; dp_m = p; end
      else if (pv_m) begin act_m = pend_m; dp_m = pdp_m; end
      pv_m = 1'b0;
    end else if (ld) begin
      pend_m = d; pdp_m = p; pv_m = 1'b1;
    end
    en_prev = en;
    t++;
    @(negedge clk);
  endtask
  task automatic run(input int n, input logic [3:0] en);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, en);
  endtask
  task automatic to_phase(input int ph, input logic [3:0] en);
    while (t % 32 != ph) step(1'b0, 16'h0, 4'h0, en);
  endtask
  initial begin
    bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.digit_en = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_an_n", bus.an_n, 4'hF);
    check("rst_dp_n", bus.dp_n, 1'b1);
    check("rst_nib", bus.nib_out, 4'h0);
    check("rst_tick", bus.frame_tick, 1'b0);
    rst_n = 1'b1;
    run(40, 4'hF);
    step(1'b1, 16'h1234, 4'h0, 4'hF);
    to_phase(31, 4'hF);
    run(33, 4'hF);
    step(1'b1, 16'h5555, 4'h3, 4'hF);
    to_phase(31, 4'hF);
    step(1'b1, 16'hABCD, 4'h0, 4'hF);
    run(64, 4'hF);
    run(64, 4'b0101);
    step(1'b1, 16'h0005, 4'b0010, 4'hF);
    run(96, 4'hF);
    en_r = 4'hF;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0) en_r = 4'($urandom);
      step($urandom_range(9) == 0, 16'($urandom), 4'($urandom), en_r);
    end
    step(1'b1, 16'h8888, 4'hF, 4'hF);
    to_phase(31, 4'hF);
    run(37, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check("async_an_n", bus.an_n, 4'hF);
    check("async_dp_n", bus.dp_n, 1'b1);
    check("async_nib", bus.nib_out, 4'h0);
    check("async_tick", bus.frame_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.load = 1'b0;
    model_reset();
    run(70, 4'hF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
